// File: rtl/lane_pkg.sv
// lane_pkg: FSM state encoding and derived-constant helpers shared by lane_mask_reader.
// Latency: none (types, functions and constants only).
// Backpressure: none.
// Contents: lane_state_e, f_ppw/f_n/f_clog2_min1 helpers, default-geometry constants.
package lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ     = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_CLR = 2'd3
  } lane_state_e;

  // Pixels packed per output word.
  function automatic int f_ppw(input int bus_width, input int num_lanes);
    return bus_width / num_lanes;
  endfunction

  // Pixels per frame.
  function automatic int f_n(input int width, input int height);
    return width * height;
  endfunction

  // Counter width that stays at least 1 bit for degenerate ranges.
  function automatic int f_clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Constants for the default 64x32, 4-lane, 32-bit configuration.
  localparam int PPW             = f_ppw(32, 4);
  localparam int N               = f_n(64, 32);
  localparam int WORDS_PER_FRAME = N / PPW;
  localparam int ADDR_W          = $clog2(N);

endpackage

// File: rtl/lane_word_fifo.sv
// lane_word_fifo: synchronous word FIFO with occupancy count for the mask readout path.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the writer must not push while full (asserted).
// Ports: clk/rst_n, i_push + i_push_dat in, i_pop in, o_head/o_empty/o_count out.
module lane_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int LP_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LP_CNT_W = $clog2(DEPTH + 1);
  localparam logic [LP_PTR_W-1:0] LP_PTR_LAST = LP_PTR_W'(DEPTH - 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_FULL = LP_CNT_W'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [LP_PTR_W-1:0] r_wr_ptr;
  logic [LP_PTR_W-1:0] r_rd_ptr;
  logic [LP_CNT_W-1:0] r_count;
  logic                w_full;
  logic                w_wr;
  logic                w_rd;

  assign w_full  = (r_count == LP_CNT_FULL);
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push & ~w_full;
  assign w_rd    = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage carries no reset; the reader gates the head with the valid flag.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == LP_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The read-side stall rule must keep the writer off a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/lane_mask_reader.sv
// lane_mask_reader: streams a completed lane mask from frame BRAM as packed words with EOF.
// Latency: first word valid PPW+2 cycles after i_frame_ready is sampled high in IDLE.
// Backpressure: valid/ready output; BRAM reads stall while FIFO occupancy exceeds DEPTH-2.
// Ports: clk/rst_n; i_frame_ready in; bram_rd_en/bram_rd_addr out, bram_rd_data in;
//        o_data/o_valid/o_last out, i_ready in; o_busy/o_frame_done/o_overrun status.
module lane_mask_reader
  import lane_pkg::*;
#(
  parameter int OUT_WIDTH  = 64,
  parameter int OUT_HEIGHT = 32,
  parameter int NUM_LANES  = 4,
  parameter int BUS_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    i_frame_ready,
  output logic                                    bram_rd_en,
  output logic [$clog2(OUT_WIDTH*OUT_HEIGHT)-1:0] bram_rd_addr,
  input  logic [NUM_LANES-1:0]                    bram_rd_data,
  output logic [BUS_WIDTH-1:0]                    o_data,
  output logic                                    o_valid,
  input  logic                                    i_ready,
  output logic                                    o_last,
  output logic                                    o_busy,
  output logic                                    o_frame_done,
  output logic                                    o_overrun
);
  localparam int LP_PPW    = f_ppw(BUS_WIDTH, NUM_LANES);
  localparam int LP_N      = f_n(OUT_WIDTH, OUT_HEIGHT);
  localparam int LP_WPF    = LP_N / LP_PPW;
  localparam int LP_ADDR_W = $clog2(LP_N);
  localparam int LP_CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LP_K_W    = f_clog2_min1(LP_PPW);
  localparam int LP_WC_W   = f_clog2_min1(LP_WPF);

  localparam logic [LP_ADDR_W:0]  LP_RD_END     = (LP_ADDR_W+1)'(LP_N);
  localparam logic [LP_ADDR_W:0]  LP_RD_LAST    = (LP_ADDR_W+1)'(LP_N - 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_RD_MAX = LP_CNT_W'(FIFO_DEPTH - 2);
  localparam logic [LP_K_W-1:0]   LP_K_LAST     = LP_K_W'(LP_PPW - 1);
  localparam logic [LP_WC_W-1:0]  LP_WC_LAST    = LP_WC_W'(LP_WPF - 1);

  lane_state_e          r_state;
  lane_state_e          w_next;
  logic [LP_ADDR_W:0]   r_rd_cnt;      // reads issued this frame; one spare bit marks "all issued"
  logic [LP_K_W-1:0]    r_pix_k;       // slot of the next returning pixel within its word
  logic [LP_WC_W-1:0]   r_word_cnt;    // words pushed this frame
  logic                 r_ret_vld;     // BRAM data is valid this cycle
  logic [BUS_WIDTH-1:0] r_pack;
  logic [BUS_WIDTH-1:0] w_pack_nxt;
  logic                 r_frame_ready_d;
  logic                 w_start;
  logic                 w_rd_issue;
  logic                 w_push;
  logic [BUS_WIDTH:0]   w_push_dat;
  logic                 w_pop;
  logic [BUS_WIDTH:0]   w_head;
  logic                 w_fifo_empty;
  logic [LP_CNT_W-1:0]  w_fifo_cnt;

  assign w_start = (r_state == ST_IDLE) & i_frame_ready;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_frame_ready) w_next = ST_READ;
      ST_READ:     if (w_rd_issue && (r_rd_cnt == LP_RD_LAST)) w_next = ST_DRAIN;
      ST_DRAIN:    if (w_pop && w_head[BUS_WIDTH]) w_next = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!i_frame_ready) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // The stall threshold leaves room for the word still being assembled from in-flight reads.
  always_comb begin
    w_rd_issue   = (r_state == ST_READ) && (r_rd_cnt != LP_RD_END) &&
                   (w_fifo_cnt <= LP_CNT_RD_MAX);
    o_busy       = (r_state == ST_READ) || (r_state == ST_DRAIN);
    o_frame_done = (r_state == ST_DRAIN) && w_pop && w_head[BUS_WIDTH];
    o_overrun    = o_busy && r_frame_ready_d && !i_frame_ready;
  end

  assign bram_rd_en   = w_rd_issue;
  assign bram_rd_addr = r_rd_cnt[LP_ADDR_W-1:0];

  // Merge the returning pixel so a completing word is pushed on the same edge.
  always_comb begin
    w_pack_nxt = r_pack;
    w_pack_nxt[r_pix_k*NUM_LANES +: NUM_LANES] = bram_rd_data;
  end

  assign w_push     = r_ret_vld && (r_pix_k == LP_K_LAST);
  assign w_push_dat = {(r_word_cnt == LP_WC_LAST), w_pack_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt        <= '0;
      r_pix_k         <= '0;
      r_word_cnt      <= '0;
      r_ret_vld       <= 1'b0;
      r_pack          <= '0;
      r_frame_ready_d <= 1'b0;
    end else begin
      r_ret_vld       <= w_rd_issue;
      r_frame_ready_d <= i_frame_ready;
      if (r_ret_vld) begin
        r_pack <= w_pack_nxt;
      end
      if (w_start) begin
        r_rd_cnt   <= '0;
        r_pix_k    <= '0;
        r_word_cnt <= '0;
      end else begin
        if (w_rd_issue) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
        if (r_ret_vld) begin
          if (r_pix_k == LP_K_LAST) begin
            r_pix_k    <= '0;
            r_word_cnt <= r_word_cnt + 1'b1;
          end else begin
            r_pix_k <= r_pix_k + 1'b1;
          end
        end
      end
    end
  end

  lane_word_fifo #(
    .WIDTH (BUS_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_cnt)
  );

  assign o_valid = ~w_fifo_empty;
  assign w_pop   = o_valid & i_ready;
  // Gate the head so data/last read as zero whenever nothing is offered.
  assign o_data  = o_valid ? w_head[BUS_WIDTH-1:0] : '0;
  assign o_last  = o_valid & w_head[BUS_WIDTH];

endmodule

// File: tb/tb_lane_mask_reader.sv
module tb_lane_mask_reader;
  localparam int N     = 2048;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, i_frame_ready, i_ready, sel;
  logic        rd_en_a, rd_en_b, vld_a, vld_b, last_a, last_b;
  logic        busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;
  logic [10:0] addr_a, addr_b;
  logic [3:0]  rdat_a, rdat_b;
  logic [31:0] data_a;
  logic [63:0] data_b;
  logic [3:0]  pix [N];
  int          errs = 0;
  int          checks = 0;
  logic [63:0] cap_w0, cap_w1;

  always #5 clk = ~clk;

  lane_mask_reader dut_a (
    .clk(clk), .rst_n(rst_n), .i_frame_ready(i_frame_ready),
    .bram_rd_en(rd_en_a), .bram_rd_addr(addr_a), .bram_rd_data(rdat_a),
    .o_data(data_a), .o_valid(vld_a), .i_ready(i_ready), .o_last(last_a),
    .o_busy(busy_a), .o_frame_done(done_a), .o_overrun(ovr_a)
  );

  lane_mask_reader #(.BUS_WIDTH(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_frame_ready(i_frame_ready),
    .bram_rd_en(rd_en_b), .bram_rd_addr(addr_b), .bram_rd_data(rdat_b),
    .o_data(data_b), .o_valid(vld_b), .i_ready(i_ready), .o_last(last_b),
    .o_busy(busy_b), .o_frame_done(done_b), .o_overrun(ovr_b)
  );

  // BRAM models: one-cycle read latency, garbage when no read was issued.
  always @(posedge clk) rdat_a <= rd_en_a ? pix[addr_a] : 4'($urandom);
  always @(posedge clk) rdat_b <= rd_en_b ? pix[addr_b] : 4'($urandom);

  // Monitored DUT selected by sel.
  logic        m_rd_en, m_vld, m_last, m_busy, m_done, m_ovr;
  logic [10:0] m_addr;
  logic [63:0] m_data;
  assign m_rd_en = sel ? rd_en_b : rd_en_a;
  assign m_addr  = sel ? addr_b  : addr_a;
  assign m_data  = sel ? data_b  : {32'h0, data_a};
  assign m_vld   = sel ? vld_b   : vld_a;
  assign m_last  = sel ? last_b  : last_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_ovr   = sel ? ovr_b   : ovr_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{data_a, vld_a, last_a, rd_en_a, addr_a, busy_a, done_a, ovr_a,
             data_b, vld_b, last_b, rd_en_b, addr_b, busy_b, done_b, ovr_b};
  endfunction

  // Expected word w: pixel k of the word sits at bits [4k +: 4], lowest address first.
  function automatic logic [63:0] exp_word(input int w, input int ppw);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < ppw; k++) v[4*k +: 4] = pix[w*ppw + k];
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) pix[i] = 4'($urandom);
  endtask

  // Call just after a negedge with the DUT in IDLE. Cycle 0 ends at the next posedge.
  // Expected FIFO occupancy in cycle c = words completed by reads up to c-2 minus pops up to c-1.
  task automatic stream_frame(input int mode, input int drop_c, input int rst_c, input int exp_ovr);
    int ppw, wpf, r1, r2, pops, cnt, wi, first_vld, done_c, fd_cnt, ovr_cnt, extra;
    int rd_bad, addr_bad, vld_bad, stall_bad, last_bad, fd_bad, busy_bad, ovf;
    logic prev_stall, hs, fin;
    logic [63:0] prev_dat;
    ppw = sel ? 16 : 8;
    wpf = N / ppw;
    r1 = 0; r2 = 0; pops = 0; wi = 0; first_vld = 0; done_c = 0; fd_cnt = 0; ovr_cnt = 0;
    extra = 0; rd_bad = 0; addr_bad = 0; vld_bad = 0; stall_bad = 0; last_bad = 0;
    fd_bad = 0; busy_bad = 0; ovf = 0; prev_stall = 1'b0; prev_dat = '0; fin = 1'b0;
    i_frame_ready = 1'b1;
    for (int c = 1; c <= 12000 && !fin; c++) begin
      @(negedge clk);
      i_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (c == drop_c) i_frame_ready = 1'b0;
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(any_out()), 0);
        return;
      end
      #1;
      if (done_c != 0) begin
        chk("busy_after_done", 64'(m_busy), 0);
        fin = 1'b1;
      end else begin
        cnt = r2 / ppw - pops;
        if (cnt > DEPTH) ovf++;
        if (m_rd_en !== ((r1 < N) && (cnt <= DEPTH - 2))) rd_bad++;
        if (m_rd_en && (m_addr !== 11'(r1))) addr_bad++;
        if (m_vld !== (cnt > 0)) vld_bad++;
        if (prev_stall && ((m_vld !== 1'b1) || (m_data !== prev_dat))) stall_bad++;
        if (m_busy !== 1'b1) busy_bad++;
        if (m_ovr) ovr_cnt++;
        hs = m_vld & i_ready;
        if (m_vld && (m_last !== (wi == wpf - 1))) last_bad++;
        if (m_done !== (hs && (wi == wpf - 1))) fd_bad++;
        if (m_done) fd_cnt++;
        if (m_vld && first_vld == 0) first_vld = c;
        if (hs) begin
          if (wi < wpf) begin
            chk("word", m_data, exp_word(wi, ppw));
            if (wi == 0) cap_w0 = m_data;
            if (wi == 1) cap_w1 = m_data;
            if (wi == wpf - 1) done_c = c;
          end else begin
            extra++;
          end
          wi++;
        end
        prev_stall = m_vld & ~i_ready;
        prev_dat   = m_data;
        r2 = r1;
        if (m_rd_en) r1++;
        if (hs) pops++;
      end
    end
    if (!fin) chk("frame_timeout", 1, 0);
    chk("first_valid_cycle", first_vld, ppw + 2);
    chk("word_count", wi, wpf);
    if (mode == 0) chk("done_cycle", done_c, N + 2);
    chk("frame_done_pulses", fd_cnt, 1);
    chk("overrun_pulses", ovr_cnt, exp_ovr);
    chk("read_issue_rule", rd_bad, 0);
    chk("read_address_seq", addr_bad, 0);
    chk("fifo_overflow", ovf, 0);
    chk("valid_vs_occupancy", vld_bad, 0);
    chk("head_stable_stall", stall_bad, 0);
    chk("last_flag", last_bad, 0);
    chk("frame_done_timing", fd_bad, 0);
    chk("busy_during_frame", busy_bad, 0);
    chk("extra_words", extra, 0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; i_frame_ready = 1'b0; i_ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < N; i++) pix[i] = 4'(i);
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", 64'(any_out()), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("idle_outputs", 64'(any_out()), 0);
    @(negedge clk);

    // Address pattern, always ready.
    stream_frame(0, 0, 0, 0);
    chk("word0_pattern", cap_w0, 64'h76543210);
    chk("word1_pattern", cap_w1, 64'hFEDCBA98);

    // Level held high after completion must not restart.
    bad = 0;
    repeat (500) begin
      @(negedge clk); #1;
      if (rd_en_a | vld_a | busy_a | done_a | ovr_a) bad++;
    end
    chk("no_restart_while_high", bad, 0);
    @(negedge clk); i_frame_ready = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (ovr_a | busy_a) bad++;
    end
    chk("clear_no_overrun", bad, 0);
    @(negedge clk);

    // Same pattern with random backpressure; addresses restart at 0.
    stream_frame(1, 0, 0, 0);
    @(negedge clk); i_frame_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Frame-ready dropped mid-frame.
    fill_random();
    stream_frame(0, 1000, 0, 1);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-frame, then a full frame from address 0.
    fill_random();
    stream_frame(0, 0, 700, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stream_frame(1, 0, 0, 0);
    @(negedge clk); i_frame_ready = 1'b0;
    repeat (50) @(negedge clk);

    // 64-bit bus instance.
    sel = 1'b1;
    fill_random();
    stream_frame(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
